// File: rtl/fifo_thresh.sv
// Single-clock first-word-fall-through FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and synchronous flush.
module fifo_thresh #(
    parameter int unsigned BUSW   = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AF_LVL = DEPTH - 4,
    parameter int unsigned AE_LVL = 4,
    parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BUSW-1:0] datain,
    input  logic            pull,
    output logic [BUSW-1:0] dataout,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [CW-1:0]   count,
    input  logic            flush,
    input  logic            clr_err,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BUSW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          full_nxt, empty_nxt, af_nxt, ae_nxt;
    logic          ovf_nxt, udf_nxt;
    logic          wr_en, rd_en;

    // Wrap at DEPTH-1 so non-power-of-2 depths use every slot
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Accepts are qualified by the registered flags only
    assign wr_en = push && !full;
    assign rd_en = pull && !empty;

    assign dataout = mem[rd_ptr];

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        ovf_nxt    = overflow;
        udf_nxt    = underflow;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (wr_en) wr_ptr_nxt = ptr_inc(wr_ptr);
            if (rd_en) rd_ptr_nxt = ptr_inc(rd_ptr);
            if (wr_en && !rd_en)      count_nxt = count + CW'(1);
            else if (!wr_en && rd_en) count_nxt = count - CW'(1);
        end

        // Set takes priority over clear
        if (clr_err) begin
            ovf_nxt = 1'b0;
            udf_nxt = 1'b0;
        end
        if (push && full && !flush)  ovf_nxt = 1'b1;
        if (pull && empty && !flush) udf_nxt = 1'b1;

        full_nxt  = (count_nxt == CW'(DEPTH));
        empty_nxt = (count_nxt == '0);
        af_nxt    = (count_nxt >= CW'(AF_LVL));
        ae_nxt    = (count_nxt <= CW'(AE_LVL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LVL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= full_nxt;
            empty        <= empty_nxt;
            almost_full  <= af_nxt;
            almost_empty <= ae_nxt;
            overflow     <= ovf_nxt;
            underflow    <= udf_nxt;
        end
    end

    // Storage has no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (wr_en && !flush && !rst) mem[wr_ptr] <= datain;
    end

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed bench for fifo_thresh (BUSW=8, DEPTH=8, AF_LVL=6, AE_LVL=1); read data is
// checked by a monitor against a queue of expected words, flags are checked inline.
module tb_fifo_thresh;

    localparam int unsigned BUSW = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            push, pull, flush, clr_err;
    logic [BUSW-1:0] datain;
    logic [BUSW-1:0] dataout;
    logic            full, empty, almost_full, almost_empty;
    logic [CW-1:0]   count;
    logic            overflow, underflow;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [BUSW-1:0] exp_q [$];

    fifo_thresh #(.BUSW(BUSW), .DEPTH(DEPTH), .AF_LVL(6), .AE_LVL(1)) dut (
        .clk(clk), .rst(rst), .push(push), .datain(datain), .pull(pull),
        .dataout(dataout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .flush(flush), .clr_err(clr_err),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted pull must present the oldest expected word
    always @(negedge clk) begin
        if (!rst && !flush && pull && !empty) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(dataout), 32'hDEAD);
            end else begin
                chk("pop_data", 32'(dataout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_flags(input string tag, input int c, input logic ov, input logic un);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_empty"}, 32'(empty), 32'(c == 0));
        chk({tag, "_full"}, 32'(full), 32'(c == 8));
        chk({tag, "_afull"}, 32'(almost_full), 32'(c >= 6));
        chk({tag, "_aempty"}, 32'(almost_empty), 32'(c <= 1));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
        chk({tag, "_udf"}, 32'(underflow), 32'(un));
    endtask

    task automatic push_word(input logic [BUSW-1:0] d);
        push = 1'b1; datain = d; exp_q.push_back(d);
        tick();
        push = 1'b0;
    endtask

    initial begin
        rst = 1'b1; push = 0; pull = 0; flush = 0; clr_err = 0; datain = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_flags("reset", 0, 0, 0);

        // 1: fill with 0x01..0x08, head stays 0x01
        for (int i = 1; i <= 8; i++) begin
            push_word(8'(i));
            check_flags("fill", i, 0, 0);
            chk("fill_head", 32'(dataout), 32'h01);
        end

        // 2: push while full, then drain in order
        push = 1'b1; datain = 8'hAA;
        tick();
        push = 1'b0;
        check_flags("ovf", 8, 1, 0);
        chk("ovf_head", 32'(dataout), 32'h01);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'h0);
        pull = 1'b1;
        repeat (8) tick();
        pull = 1'b0;
        check_flags("drain", 0, 0, 0);
        chk("drain_q", 32'(exp_q.size()), 32'h0);

        // 3: four entries, then 20 cycles of simultaneous push/pull
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
        for (int i = 0; i < 20; i++) begin
            push = 1'b1; pull = 1'b1; datain = 8'(8'h20 + i);
            exp_q.push_back(datain);
            tick();
            chk("stream_count", 32'(count), 32'd4);
        end
        push = 1'b0;
        repeat (4) tick();
        pull = 1'b0;
        check_flags("stream_end", 0, 0, 0);
        chk("stream_q", 32'(exp_q.size()), 32'h0);

        // 4: push+pull on empty: pull rejected, underflow set
        push = 1'b1; pull = 1'b1; datain = 8'h55; exp_q.push_back(8'h55);
        tick();
        push = 1'b0; pull = 1'b0;
        check_flags("udf", 1, 0, 1);
        chk("udf_head", 32'(dataout), 32'h55);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("udf_clr", 32'(underflow), 32'h0);

        // 5: from full, push+pull: pull accepted, push rejected
        for (int i = 0; i < 7; i++) push_word(8'(8'h60 + i));
        check_flags("full5", 8, 0, 0);
        push = 1'b1; pull = 1'b1; datain = 8'h77;
        tick();
        push = 1'b0; pull = 1'b0;
        check_flags("pp_full", 7, 1, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("pp_clr", 32'(overflow), 32'h0);

        // 6: flush with push at 5 entries; overflow preserved
        push_word(8'h67);
        push = 1'b1; datain = 8'hEE; tick(); push = 1'b0;
        chk("pre_flush_ovf", 32'(overflow), 32'h1);
        pull = 1'b1; repeat (3) tick(); pull = 1'b0;
        check_flags("pre_flush", 5, 1, 0);
        flush = 1'b1; push = 1'b1; datain = 8'h99;
        exp_q.delete();
        tick();
        flush = 1'b0; push = 1'b0;
        check_flags("flush", 0, 1, 0);

        // Async reset mid-fill
        for (int i = 0; i < 3; i++) push_word(8'(8'hB0 + i));
        chk("prerst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check_flags("async_rst", 0, 0, 0);
        tick();
        #1 rst = 1'b0;
        tick();
        check_flags("post_rst", 0, 0, 0);

        // Post-reset round trip
        push_word(8'hC3);
        check_flags("post_push", 1, 0, 0);
        pull = 1'b1; tick(); pull = 1'b0;
        check_flags("post_pull", 0, 0, 0);
        chk("final_q", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
